// File: rtl/sw_array_driver_pkg.sv
// Shared constants, FSM encoding and helpers for the Smith-Waterman chain driver.
// The column buffers and the driver both import this package.
package sw_pkg;

   localparam int PE_LENGTH = 128;
   localparam int T_MAX_LEN = 1024;
   localparam int ADDR_W    = $clog2(T_MAX_LEN);
   localparam int CNT_W     = ADDR_W + 1;
   localparam int DATA_W    = 12;
   localparam int PASS_W    = 4;
   localparam int SYM_W     = 2;
   localparam int FB_W      = 3 * DATA_W;

   localparam logic [CNT_W-1:0] T_LEN_MAX = CNT_W'(T_MAX_LEN);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEGREQ,
      ST_FEED,
      ST_DRAIN,
      ST_DONE
   } sw_state_e;

   function automatic logic [DATA_W-1:0] umax(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sw_array_driver_if.sv
// Bundles configuration, loader handshake, target stream, chain column and status signals.
// The driver takes the slave modport; the environment around it takes the master modport.
interface sw_array_driver_if;
   import sw_pkg::*;

   logic              cfg_start;
   logic [CNT_W-1:0]  cfg_t_len;
   logic [PASS_W-1:0] cfg_num_pass;
   logic              seg_req;
   logic [PASS_W-1:0] seg_idx;
   logic              seg_ack;
   logic              tgt_valid;
   logic              tgt_ready;
   logic [SYM_W-1:0]  tgt_data;
   logic              arr_valid_in;
   logic [SYM_W-1:0]  arr_t_in;
   logic [DATA_W-1:0] arr_v_in;
   logic [DATA_W-1:0] arr_f_in;
   logic [DATA_W-1:0] arr_max_in;
   logic              arr_valid_out;
   logic [DATA_W-1:0] arr_v_out;
   logic [DATA_W-1:0] arr_f_out;
   logic [DATA_W-1:0] arr_max_out;
   logic              busy;
   logic              done;
   logic [DATA_W-1:0] score;
   logic              cfg_err;

   modport master (
      output cfg_start, cfg_t_len, cfg_num_pass, seg_ack, tgt_valid, tgt_data,
             arr_valid_out, arr_v_out, arr_f_out, arr_max_out,
      input  seg_req, seg_idx, tgt_ready, arr_valid_in, arr_t_in, arr_v_in, arr_f_in,
             arr_max_in, busy, done, score, cfg_err
   );

   modport slave (
      input  cfg_start, cfg_t_len, cfg_num_pass, seg_ack, tgt_valid, tgt_data,
             arr_valid_out, arr_v_out, arr_f_out, arr_max_out,
      output seg_req, seg_idx, tgt_ready, arr_valid_in, arr_t_in, arr_v_in, arr_f_in,
             arr_max_in, busy, done, score, cfg_err
   );

endinterface

// File: rtl/sw_array_driver_col_buf.sv
// Single-port-write, synchronous-read column buffer. A read and write to the same
// address in one cycle returns the old contents.
module sw_col_buf
   import sw_pkg::*;
#(
   parameter  int WIDTH = SYM_W,
   parameter  int DEPTH = T_MAX_LEN,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             re_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)      rdata_q <= '0;
      else if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/sw_array_driver.sv
// Feeds target symbols into the PE chain, buffers each pass's output column and replays it
// as the next pass's input, and reports the best score of the final pass.
module sw_array_driver
   import sw_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   sw_array_driver_if.slave  bus
);

   sw_state_e         state_q;
   logic [CNT_W-1:0]  t_len_q;
   logic [CNT_W-1:0]  rd_cnt_q;
   logic [CNT_W-1:0]  wr_cnt_q;
   logic [PASS_W-1:0] pass_q;
   logic [PASS_W-1:0] num_pass_q;
   logic              seg_req_q;
   logic              busy_q;
   logic              done_q;
   logic              cfg_err_q;
   logic              arr_vld_q;
   logic [SYM_W-1:0]  arr_t_q;
   logic [DATA_W-1:0] score_q;

   logic              pass0;
   logic              tgt_rdy;
   logic              tgt_hs;
   logic              fb_rd;
   logic              issue;
   logic              last_rd;
   logic              out_acc;
   logic              last_pass;
   logic              cfg_bad;
   logic [PASS_W-1:0] pass_d;
   logic [CNT_W-1:0]  wr_cnt_d;
   logic [SYM_W-1:0]  tbuf_rdata;
   logic [FB_W-1:0]   fbuf_rdata;

   assign pass0     = (pass_q == '0);
   assign tgt_rdy   = (state_q == ST_FEED) && pass0;
   assign tgt_hs    = tgt_rdy && bus.tgt_valid;
   assign fb_rd     = (state_q == ST_FEED) && !pass0;
   assign issue     = tgt_hs || fb_rd;
   assign last_rd   = (rd_cnt_q == t_len_q - CNT_W'(1));
   // Chain outputs only count while a pass is live and before its column is complete.
   assign out_acc   = bus.arr_valid_out && (wr_cnt_q < t_len_q) &&
                      ((state_q == ST_FEED) || (state_q == ST_DRAIN));
   assign wr_cnt_d  = wr_cnt_q + CNT_W'(out_acc);
   assign last_pass = (pass_q == num_pass_q - PASS_W'(1));
   assign pass_d    = pass_q + PASS_W'(1);
   assign cfg_bad   = (bus.cfg_t_len == '0) || (bus.cfg_t_len > T_LEN_MAX) ||
                      (bus.cfg_num_pass == '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         t_len_q    <= '0;
         rd_cnt_q   <= '0;
         wr_cnt_q   <= '0;
         pass_q     <= '0;
         num_pass_q <= '0;
         seg_req_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         cfg_err_q  <= 1'b0;
         arr_vld_q  <= 1'b0;
         arr_t_q    <= '0;
         score_q    <= '0;
      end else begin
         arr_vld_q <= issue;
         if (tgt_hs) arr_t_q  <= bus.tgt_data;
         if (issue)  rd_cnt_q <= rd_cnt_q + CNT_W'(1);
         if (out_acc) begin
            wr_cnt_q <= wr_cnt_d;
            if (last_pass) score_q <= umax(score_q, bus.arr_max_out);
         end
         case (state_q)
            ST_IDLE: begin
               if (bus.cfg_start) begin
                  t_len_q    <= bus.cfg_t_len;
                  num_pass_q <= bus.cfg_num_pass;
                  pass_q     <= '0;
                  score_q    <= '0;
                  rd_cnt_q   <= '0;
                  wr_cnt_q   <= '0;
                  cfg_err_q  <= cfg_bad;
                  if (cfg_bad) begin
                     done_q  <= 1'b1;
                     state_q <= ST_DONE;
                  end else begin
                     seg_req_q <= 1'b1;
                     busy_q    <= 1'b1;
                     state_q   <= ST_SEGREQ;
                  end
               end
            end
            ST_SEGREQ: begin
               if (bus.seg_ack) begin
                  seg_req_q <= 1'b0;
                  state_q   <= ST_FEED;
               end
            end
            ST_FEED: begin
               if (issue && last_rd) state_q <= ST_DRAIN;
            end
            ST_DRAIN: begin
               // Finishing on the cycle the last output arrives keeps done one cycle behind it.
               if (wr_cnt_d == t_len_q) begin
                  pass_q <= pass_d;
                  if (pass_d < num_pass_q) begin
                     rd_cnt_q  <= '0;
                     wr_cnt_q  <= '0;
                     seg_req_q <= 1'b1;
                     state_q   <= ST_SEGREQ;
                  end else begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               done_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   sw_col_buf #(.WIDTH(SYM_W), .DEPTH(T_MAX_LEN)) u_tbuf (
      .clk     (clk),
      .rst     (rst),
      .we_i    (tgt_hs),
      .waddr_i (rd_cnt_q[ADDR_W-1:0]),
      .wdata_i (bus.tgt_data),
      .re_i    (fb_rd),
      .raddr_i (rd_cnt_q[ADDR_W-1:0]),
      .rdata_o (tbuf_rdata)
   );

   sw_col_buf #(.WIDTH(FB_W), .DEPTH(T_MAX_LEN)) u_fbuf (
      .clk     (clk),
      .rst     (rst),
      .we_i    (out_acc),
      .waddr_i (wr_cnt_q[ADDR_W-1:0]),
      .wdata_i ({bus.arr_v_out, bus.arr_f_out, bus.arr_max_out}),
      .re_i    (fb_rd),
      .raddr_i (rd_cnt_q[ADDR_W-1:0]),
      .rdata_o (fbuf_rdata)
   );

   // Pass 0 drives from the handshake register; later passes drive straight from the buffers.
   assign bus.arr_t_in     = pass0 ? arr_t_q : tbuf_rdata;
   assign {bus.arr_v_in, bus.arr_f_in, bus.arr_max_in} = pass0 ? '0 : fbuf_rdata;
   assign bus.arr_valid_in = arr_vld_q;
   assign bus.tgt_ready    = tgt_rdy;
   assign bus.seg_req      = seg_req_q;
   assign bus.seg_idx      = pass_q;
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.score        = score_q;
   assign bus.cfg_err      = cfg_err_q;

endmodule
